voice_bank: RTL and testbench

- Parametrised polyphonic square-wave voice bank; successor to the fixed 7-note, key-bit-driven tone generation on the CPU's synth output path.
- N_VOICES independent voices; per-voice half-period and note-duration registers, written by the CPU through a register-write port.
- Voices sound from a timed gate or from a direct key-pressed mask; outputs are per-voice square waves plus a registered voice-count mix.

---
 rtl/voice_bank_pkg.sv | 20 ++
 rtl/voice_bank_if.sv | 32 +++
 rtl/voice_osc.sv | 78 +++++++
 rtl/voice_bank.sv | 103 ++++++++++
 tb/tb_voice_bank.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_bank_pkg.sv
// rtl/voice_bank_pkg.sv - shared register offsets and helpers for the voice bank
package voice_bank_pkg;

    localparam int REG_HALF_PERIOD = 0;
    localparam int REG_DURATION    = 1;

    function automatic int mix_width(input int n_voices);
        return $clog2(n_voices + 1);
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] bits);
        logic [4:0] count;
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(bits[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/voice_bank_if.sv
// rtl/voice_bank_if.sv - CPU register port of the voice bank (readback under VOICE_READBACK_EN)
interface voice_bank_if #(
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
`ifdef VOICE_READBACK_EN
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
`endif

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
`ifdef VOICE_READBACK_EN
        , output rd_addr
        , input  rd_data
`endif
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data
`ifdef VOICE_READBACK_EN
        , input  rd_addr
        , output rd_data
`endif
    );
endinterface

// File: rtl/voice_osc.sv
// rtl/voice_osc.sv - one voice: half-period oscillator plus timed gate countdown
module voice_osc #(
    parameter int PER_W = 16,
    parameter int DUR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              hp_we,
    input  logic              dur_we,
    input  logic [15:0]       wr_data,
    input  logic              key,
    output logic              voice_out,
    output logic              active
`ifdef VOICE_READBACK_EN
    , output logic [PER_W-1:0] half_period_q
    , output logic [DUR_W-1:0] remaining_q
`endif
);

    logic [PER_W-1:0] half_period;
    logic [PER_W-1:0] count;
    logic [DUR_W-1:0] remaining;
    logic [DUR_W-1:0] dur_val;
    logic             gate;
    logic             sounding;

    assign dur_val  = wr_data[DUR_W-1:0];
    assign sounding = (gate | key) & (half_period != '0);

`ifdef VOICE_READBACK_EN
    assign half_period_q = half_period;
    assign remaining_q   = remaining;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            half_period <= '0;
            remaining   <= '0;
            gate        <= 1'b0;
            count       <= '0;
            voice_out   <= 1'b0;
            active      <= 1'b0;
        end else begin
            if (hp_we) begin
                half_period <= wr_data[PER_W-1:0];
            end

            // A duration write overrides any tick decrement in the same cycle.
            if (dur_we) begin
                remaining <= dur_val;
                gate      <= (dur_val != '0);
            end else if (tick && remaining != '0) begin
                remaining <= remaining - 1'b1;
                if (remaining == DUR_W'(1)) begin
                    gate <= 1'b0;
                end
            end

            active <= sounding;

            // active doubles as "was sounding last cycle" to detect note entry.
            if (!sounding) begin
                count     <= '0;
                voice_out <= 1'b0;
            end else if (!active) begin
                count     <= half_period - 1'b1;
                voice_out <= 1'b0;
            end else if (count == '0) begin
                count     <= half_period - 1'b1;
                voice_out <= ~voice_out;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_bank.sv
// rtl/voice_bank.sv - polyphonic square-wave voice bank; VOICE_READBACK_EN adds register readback
module voice_bank
    import voice_bank_pkg::*;
#(
    parameter int N_VOICES = 8,
    parameter int PER_W    = 16,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 50000,
    parameter int ADDR_W   = 5
) (
    input  logic                              clock,
    input  logic                              reset,
    voice_bank_if.slave                       bus,
    input  logic [N_VOICES-1:0]               key_pressed,
    output logic [N_VOICES-1:0]               voice_out,
    output logic [N_VOICES-1:0]               active,
    output logic [mix_width(N_VOICES)-1:0]    mix_out
);

    localparam int MIX_W = mix_width(N_VOICES);
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] presc;
    logic          tick;

    assign tick = (presc == TW'(TICK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

`ifdef VOICE_READBACK_EN
    logic [PER_W-1:0] hp_q  [N_VOICES];
    logic [DUR_W-1:0] rem_q [N_VOICES];
`endif

    for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
        logic hp_we;
        logic dur_we;

        assign hp_we  = bus.wr_en && (bus.wr_addr == ADDR_W'(2 * v + REG_HALF_PERIOD));
        assign dur_we = bus.wr_en && (bus.wr_addr == ADDR_W'(2 * v + REG_DURATION));

        voice_osc #(
            .PER_W (PER_W),
            .DUR_W (DUR_W)
        ) u_osc (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .hp_we     (hp_we),
            .dur_we    (dur_we),
            .wr_data   (bus.wr_data),
            .key       (key_pressed[v]),
            .voice_out (voice_out[v]),
            .active    (active[v])
`ifdef VOICE_READBACK_EN
            , .half_period_q (hp_q[v])
            , .remaining_q   (rem_q[v])
`endif
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mix_out <= '0;
        end else begin
            mix_out <= MIX_W'(popcount(16'(voice_out)));
        end
    end

`ifdef VOICE_READBACK_EN
    logic [15:0] rd_next;

    // Duration reads return the live countdown, not the value last written.
    always_comb begin
        rd_next = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (bus.rd_addr == ADDR_W'(2 * v + REG_HALF_PERIOD)) begin
                rd_next = 16'(hp_q[v]);
            end
            if (bus.rd_addr == ADDR_W'(2 * v + REG_DURATION)) begin
                rd_next = 16'(rem_q[v]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_next;
        end
    end
`endif

endmodule

// File: tb/tb_voice_bank.sv
// tb/tb_voice_bank.sv - randomized and directed checks of voice_bank against a behavioural model
module tb_voice_bank;

    localparam int NV = 4;
    localparam int TD = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NV-1:0] key_pressed = '0;
    logic [NV-1:0] voice_out;
    logic [NV-1:0] active;
    logic [2:0]    mix_out;

    voice_bank_if #(.ADDR_W(5)) bus ();

    voice_bank #(
        .N_VOICES (NV),
        .PER_W    (16),
        .DUR_W    (16),
        .TICK_DIV (TD),
        .ADDR_W   (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .key_pressed (key_pressed),
        .voice_out   (voice_out),
        .active      (active),
        .mix_out     (mix_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: each voice tracks cycles elapsed within the current half-cycle.
    int m_hp [NV], m_rem [NV], m_gate [NV], m_act [NV], m_out [NV], m_el [NV], m_seg [NV];
    int m_mix, m_presc, m_rd;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_hp[v] = 0; m_rem[v] = 0; m_gate[v] = 0; m_act[v] = 0;
            m_out[v] = 0; m_el[v] = 0; m_seg[v] = 0;
        end
        m_mix = 0; m_presc = 0; m_rd = 0;
    endtask

    task automatic model_edge();
        int tick, pc, a, v, d;
        int wrote [NV];
        if (reset) begin
            model_reset();
            return;
        end
        tick    = (m_presc == TD - 1);
        m_presc = tick ? 0 : m_presc + 1;
        pc = 0;
        for (int i = 0; i < NV; i++) pc += m_out[i];
        m_mix = pc;
`ifdef VOICE_READBACK_EN
        a = int'(bus.rd_addr);
        if (a < 2 * NV) m_rd = (a % 2 == 0) ? m_hp[a / 2] : m_rem[a / 2];
        else m_rd = 0;
`endif
        for (int i = 0; i < NV; i++) begin
            wrote[i] = 0;
            if (!((m_gate[i] != 0 || key_pressed[i]) && m_hp[i] != 0)) begin
                m_out[i] = 0; m_el[i] = 0; m_act[i] = 0;
            end else if (m_act[i] == 0) begin
                m_out[i] = 0; m_el[i] = 0; m_seg[i] = m_hp[i]; m_act[i] = 1;
            end else begin
                m_el[i]++;
                if (m_el[i] == m_seg[i]) begin
                    m_out[i] ^= 1; m_el[i] = 0; m_seg[i] = m_hp[i];
                end
            end
        end
        if (bus.wr_en) begin
            a = int'(bus.wr_addr);
            d = int'(bus.wr_data);
            if (a < 2 * NV) begin
                v = a / 2;
                if (a % 2 == 0) m_hp[v] = d;
                else begin
                    m_rem[v] = d; m_gate[v] = (d != 0); wrote[v] = 1;
                end
            end
        end
        for (int i = 0; i < NV; i++) begin
            if (!wrote[i] && tick && m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_gate[i] = 0;
            end
        end
    endtask

    function automatic int pack_bits(input int b [NV]);
        int r = 0;
        for (int i = 0; i < NV; i++) r |= (b[i] & 1) << i;
        return r;
    endfunction

    task automatic compare_all();
        check("voice_out", int'(voice_out), pack_bits(m_out));
        check("active", int'(active), pack_bits(m_act));
        check("mix_out", int'(mix_out), m_mix);
`ifdef VOICE_READBACK_EN
        check("rd_data", int'(bus.rd_data), m_rd);
`endif
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all();
    endtask

    task automatic do_write(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(addr);
        bus.wr_data = 16'(data);
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    int samp [40];
    int n, r0, r1, highs, prev;

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef VOICE_READBACK_EN
        bus.rd_addr = '0;
`endif
        model_reset();
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // Key play on voice 2, half period 3.
        do_write(4, 3);
        key_pressed = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            cyc();
            samp[i] = int'(voice_out[2]);
        end
        r0 = -1; r1 = -1; highs = 0;
        for (int i = 1; i < 40; i++) begin
            if (samp[i] == 1 && samp[i-1] == 0) begin
                if (r0 < 0) r0 = i;
                else if (r1 < 0) r1 = i;
            end
        end
        for (int i = 3; i < 39; i++) highs += samp[i];
        check("key_first_rise", r0, 3);
        check("key_period", r1 - r0, 6);
        check("key_duty", highs, 18);
        key_pressed = '0;
        cyc();
        check("key_release", int'(voice_out[2]), 0);

        // Timed note on voice 1.
        do_write(2, 2);
        do_write(3, 3);
        n = 0;
        for (int i = 0; i < 35; i++) begin
            cyc();
            n += int'(active[1]);
        end
        check("note_len_in_range", int'(n >= 21 && n <= 30), 1);
        check("note_silent_after", int'(voice_out[1]), 0);

        // Half period 1 toggles every cycle.
        do_write(0, 1);
        key_pressed = 4'b0001;
        cyc();
        prev = int'(voice_out[0]);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("hp1_toggle", int'(voice_out[0]), prev ^ 1);
            prev = int'(voice_out[0]);
        end
        key_pressed = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("hp0_silent", int'(voice_out[3]), 0);
        end
        key_pressed = '0;
        do_write(8, 5);
        do_write(9, 5);
        cyc();

        // Duration 0 written mid-note clears the gate.
        do_write(3, 9);
        repeat (5) cyc();
        do_write(3, 0);
        cyc();
        check("dur0_clear", int'(active[1]), 0);

        // Duration write coincident with a tick loads without decrement.
        for (int i = 0; i < TD && m_presc != TD - 1; i++) cyc();
        check("tick_aligned", m_presc, TD - 1);
        do_write(3, 2);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            n += int'(active[1]);
        end
        check("wr_tick_len", n, 20);

        // Half period change mid-note.
        do_write(0, 4);
        key_pressed = 4'b0001;
        repeat (6) cyc();
        do_write(0, 2);
        repeat (20) cyc();

        // All voices keyed for the mix.
        do_write(0, 1); do_write(2, 2); do_write(4, 3); do_write(6, 4);
        key_pressed = 4'hF;
        repeat (60) cyc();

        for (int i = 0; i < 1500; i++) begin
            int a;
            a = $urandom_range(0, 9);
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 5'(a);
            bus.wr_data = 16'((a % 2 == 0) ? $urandom_range(0, 5) : $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) key_pressed = 4'($urandom);
`ifdef VOICE_READBACK_EN
            bus.rd_addr = 5'($urandom_range(0, 9));
`endif
            cyc();
        end
        bus.wr_en = 1'b0;

        // Asynchronous reset while voice 0 sounds.
        do_write(0, 2);
        key_pressed = 4'b0001;
        repeat (5) cyc();
        #2 reset = 1'b1;
        #1;
        check("rst_voice_out", int'(voice_out), 0);
        check("rst_active", int'(active), 0);
        check("rst_mix", int'(mix_out), 0);
        model_reset();
        @(negedge clock);
        cyc();
        reset = 1'b0;
        key_pressed = '0;
`ifdef VOICE_READBACK_EN
        for (int a = 0; a < 2 * NV; a++) begin
            bus.rd_addr = 5'(a);
            cyc();
            check("rst_readback", int'(bus.rd_data), 0);
        end
`endif
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
